// File: rtl/morse_producer_fifo_if.sv
// Consumer-side handshake of the Morse producer FIFO:
// head word, valid flag and acknowledge.
interface morse_producer_fifo_if #(
    parameter int W = 10
);
    logic [W-1:0] outputbits;
    logic         sent;
    logic         Ack;

    modport master (output outputbits, output sent, input Ack);
    modport slave  (input outputbits, input sent, output Ack);
endinterface

// File: rtl/morse_producer_fifo.sv
// Morse push-button encoder with timed buzzers and a committed-word FIFO.
// Optional input debounce when MORSE_DEBOUNCE_EN is defined.
module morse_producer_fifo #(
    parameter int MAX_SYMBOLS     = 5,
    parameter int BUZZ_CYCLES     = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic Dot,
    input  logic Dash,
    input  logic Space,
    input  logic EndSeq,
    input  logic Clear,
    output logic dot_buzzer,
    output logic dash_buzzer,
    output logic spa_end,
    output logic overflow,
    output logic dropped,
    morse_producer_fifo_if.master cq
);
    localparam int W  = 2 * MAX_SYMBOLS;
    localparam int CW = $clog2(MAX_SYMBOLS + 1);
    localparam int BW = $clog2(3 * BUZZ_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [W-1:0] SEP = {W{1'b1}};

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("morse_producer_fifo: illegal parameter");
    end

    typedef enum logic {IDLE, PEND_SPACE} state_t;

    logic [4:0] btn, s1, rise;
    assign btn = {Clear, EndSeq, Space, Dash, Dot};

`ifdef MORSE_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt [5];
    logic [4:0]    stable, stable_q;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            s1       <= '0;
            stable_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            s1       <= btn;
            stable_q <= stable;
            for (int i = 0; i < 5; i++) begin
                if (!s1[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DW'(DEBOUNCE_CYCLES))
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++)
            stable[i] = (db_cnt[i] == DW'(DEBOUNCE_CYCLES));
    end

    assign rise = stable & ~stable_q;
`else
    logic [4:0] s2;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;
`endif

    // Make events mutually exclusive so the decoder below is one-hot.
    logic e_clr, e_end, e_spc, e_dash, e_dot;
    assign e_clr  = rise[4];
    assign e_end  = rise[3] & ~rise[4];
    assign e_spc  = rise[2] & ~|rise[4:3];
    assign e_dash = rise[1] & ~|rise[4:2];
    assign e_dot  = rise[0] & ~|rise[4:1];

    state_t         state, state_n;
    logic [W-1:0]   buf_q, buf_n, push_word;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic           ovf_n, spa_n, push;
    logic           start_dot, start_dash, stop_buzz;

    always_comb begin
        state_n    = state;
        buf_n      = buf_q;
        cnt_n      = cnt_q;
        ovf_n      = overflow;
        spa_n      = 1'b0;
        push       = 1'b0;
        push_word  = buf_q;
        start_dot  = 1'b0;
        start_dash = 1'b0;
        stop_buzz  = 1'b0;
        if (state == PEND_SPACE) begin
            push      = 1'b1;
            push_word = SEP;
            state_n   = IDLE;
        end else begin
            unique case (1'b1)
                e_clr: begin
                    buf_n     = '0;
                    cnt_n     = '0;
                    ovf_n     = 1'b0;
                    stop_buzz = 1'b1;
                end
                e_end: begin
                    spa_n = 1'b1;
                    if (cnt_q != '0) begin
                        push  = 1'b1;
                        buf_n = '0;
                        cnt_n = '0;
                        ovf_n = 1'b0;
                    end
                end
                e_spc: begin
                    spa_n = 1'b1;
                    push  = 1'b1;
                    if (cnt_q == '0) begin
                        push_word = SEP;
                    end else begin
                        buf_n   = '0;
                        cnt_n   = '0;
                        state_n = PEND_SPACE;
                    end
                end
                e_dash, e_dot: begin
                    if (cnt_q < CW'(MAX_SYMBOLS)) begin
                        buf_n      = {buf_q[W-3:0], e_dash, e_dot};
                        cnt_n      = cnt_q + 1'b1;
                        start_dash = e_dash;
                        start_dot  = e_dot;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [BW-1:0] dot_cnt, dash_cnt;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state    <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            spa_end  <= 1'b0;
            dot_cnt  <= '0;
            dash_cnt <= '0;
        end else begin
            state    <= state_n;
            buf_q    <= buf_n;
            cnt_q    <= cnt_n;
            overflow <= ovf_n;
            spa_end  <= spa_n;
            if (start_dot) begin
                dot_cnt  <= BW'(BUZZ_CYCLES);
                dash_cnt <= '0;
            end else if (start_dash) begin
                dot_cnt  <= '0;
                dash_cnt <= BW'(3 * BUZZ_CYCLES);
            end else if (stop_buzz) begin
                dot_cnt  <= '0;
                dash_cnt <= '0;
            end else begin
                if (dot_cnt != '0)  dot_cnt  <= dot_cnt - 1'b1;
                if (dash_cnt != '0) dash_cnt <= dash_cnt - 1'b1;
            end
        end
    end

    assign dot_buzzer  = (dot_cnt != '0);
    assign dash_buzzer = (dash_cnt != '0);

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          full, pop, do_push;

    assign full    = (occ == (AW+1)'(FIFO_DEPTH));
    assign pop     = cq.sent & cq.Ack;
    // A same-cycle pop frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= push & ~do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    assign cq.sent       = (occ != '0);
    assign cq.outputbits = cq.sent ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_morse_producer_fifo.sv
// Directed bench for morse_producer_fifo at default parameters.
module tb_morse_producer_fifo;
    localparam int B_DOT = 0, B_DASH = 1, B_SPC = 2, B_END = 3, B_CLR = 4;

    logic clk = 1'b0;
    logic Reset, Dot, Dash, Space, EndSeq, Clear;
    logic dot_buzzer, dash_buzzer, spa_end, overflow, dropped;
    int vectors = 0;
    int miscompares = 0;

    morse_producer_fifo_if #(.W(10)) cq ();

    morse_producer_fifo dut (
        .clk(clk), .Reset(Reset),
        .Dot(Dot), .Dash(Dash), .Space(Space),
        .EndSeq(EndSeq), .Clear(Clear),
        .dot_buzzer(dot_buzzer), .dash_buzzer(dash_buzzer),
        .spa_end(spa_end), .overflow(overflow),
        .dropped(dropped), .cq(cq)
    );

    always #5 clk = ~clk;

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_DOT:   Dot = v;
            B_DASH:  Dash = v;
            B_SPC:   Space = v;
            B_END:   EndSeq = v;
            default: Clear = v;
        endcase
    endtask

    // High for one cycle, then low; returns just after the accepting edge.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
        @(negedge clk);
    endtask

    task automatic ack1();
        cq.Ack = 1'b1;
        @(negedge clk);
        cq.Ack = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        {Dot, Dash, Space, EndSeq, Clear} = '0;
        cq.Ack = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({dot_buzzer, dash_buzzer, spa_end, overflow, dropped, cq.sent} !== 6'b0
            || cq.outputbits !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b/%h want 0",
                {dot_buzzer, dash_buzzer, spa_end, overflow, dropped, cq.sent},
                cq.outputbits);
        end
        Reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dot_endseq();
        int hi = 0;
        press(B_DOT);
        for (int i = 0; i < 12; i++) begin
            if (dot_buzzer) hi++;
            @(negedge clk);
        end
        vectors++;
        if (hi !== 8) begin
            miscompares++;
            $display("FAIL dot_buzz_len: got %0d want 8", hi);
        end
        press(B_DOT);
        press(B_DOT);
        press(B_END);
        vectors++;
        if (spa_end !== 1'b1) begin
            miscompares++;
            $display("FAIL endseq_spa_end: got %b want 1", spa_end);
        end
        @(negedge clk);
        vectors++;
        if (spa_end !== 1'b0) begin
            miscompares++;
            $display("FAIL spa_end_one_cycle: got %b want 0", spa_end);
        end
        vectors++;
        if (cq.sent !== 1'b1 || cq.outputbits !== 10'h015) begin
            miscompares++;
            $display("FAIL dot3_word: got %b/%h want 1/015",
                cq.sent, cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL dot3_drain: got %b want 0", cq.sent);
        end
    endtask

    task automatic test_dash_queue();
        int hi = 0;
        press(B_DASH);
        for (int i = 0; i < 30; i++) begin
            if (dash_buzzer) hi++;
            @(negedge clk);
        end
        vectors++;
        if (hi !== 24) begin
            miscompares++;
            $display("FAIL dash_buzz_len: got %0d want 24", hi);
        end
        press(B_DASH);
        press(B_DASH);
        press(B_END);
        press(B_DOT);
        press(B_DOT);
        press(B_DOT);
        press(B_END);
        vectors++;
        if (cq.outputbits !== 10'h02A) begin
            miscompares++;
            $display("FAIL head_dash3: got %h want 02A", cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.outputbits !== 10'h015 || cq.sent !== 1'b1) begin
            miscompares++;
            $display("FAIL head_dot3: got %b/%h want 1/015",
                cq.sent, cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL queue_empty: got %b want 0", cq.sent);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b0 || cq.outputbits !== 10'h000) begin
            miscompares++;
            $display("FAIL ack_when_empty: got %b/%h want 0/000",
                cq.sent, cq.outputbits);
        end
    endtask

    task automatic test_space();
        press(B_DOT);
        press(B_DOT);
        press(B_DOT);
        press(B_SPC);
        vectors++;
        if (spa_end !== 1'b1 || cq.outputbits !== 10'h015) begin
            miscompares++;
            $display("FAIL space_first: got %b/%h want 1/015",
                spa_end, cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b1 || cq.outputbits !== 10'h3FF) begin
            miscompares++;
            $display("FAIL space_sep: got %b/%h want 1/3FF",
                cq.sent, cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL space_drain: got %b want 0", cq.sent);
        end
        press(B_DOT);
        press(B_END);
        vectors++;
        if (cq.outputbits !== 10'h001) begin
            miscompares++;
            $display("FAIL after_space_idle: got %h want 001", cq.outputbits);
        end
        ack1();
        press(B_SPC);
        vectors++;
        if (cq.sent !== 1'b1 || cq.outputbits !== 10'h3FF) begin
            miscompares++;
            $display("FAIL space_empty_buf: got %b/%h want 1/3FF",
                cq.sent, cq.outputbits);
        end
        ack1();
        vectors++;
        if (cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL space_single_sep: got %b want 0", cq.sent);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) press(B_DOT);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_at_max: got %b want 0", overflow);
        end
        press(B_DOT);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %b want 1", overflow);
        end
        press(B_END);
        vectors++;
        if (overflow !== 1'b0 || cq.outputbits !== 10'h155) begin
            miscompares++;
            $display("FAIL ovf_commit: got %b/%h want 0/155",
                overflow, cq.outputbits);
        end
        ack1();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_q [4];
        exp_q = '{10'h002, 10'h005, 10'h00A, 10'h009};
        press(B_DOT);  press(B_END);
        press(B_DASH); press(B_END);
        press(B_DOT);  press(B_DOT);  press(B_END);
        press(B_DASH); press(B_DASH); press(B_END);
        press(B_DOT);  press(B_DOT);  press(B_DOT);
        press(B_END);
        vectors++;
        if (dropped !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_full: got %b want 1", dropped);
        end
        @(negedge clk);
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_pulse: got %b want 0", dropped);
        end
        press(B_DASH);
        press(B_DOT);
        EndSeq = 1'b1;
        @(negedge clk);
        EndSeq = 1'b0;
        cq.Ack = 1'b1;
        @(negedge clk);
        cq.Ack = 1'b0;
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL push_pop_full: got %b want 0", dropped);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cq.sent !== 1'b1 || cq.outputbits !== exp_q[i]) begin
                miscompares++;
                $display("FAIL drain_%0d: got %b/%h want 1/%h",
                    i, cq.sent, cq.outputbits, exp_q[i]);
            end
            ack1();
        end
        vectors++;
        if (cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL occupancy4: got %b want 0", cq.sent);
        end
    endtask

    task automatic test_clear_reset();
        Dot = 1'b1;
        Clear = 1'b1;
        @(negedge clk);
        Dot = 1'b0;
        Clear = 1'b0;
        @(negedge clk);
        vectors++;
        if (dot_buzzer !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_wins_buzz: got %b want 0", dot_buzzer);
        end
        press(B_END);
        vectors++;
        if (cq.sent !== 1'b0 || spa_end !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_wins_empty: got %b/%b want 0/1",
                cq.sent, spa_end);
        end
        Dot = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (dot_buzzer !== 1'b1) begin
            miscompares++;
            $display("FAIL held_dot_buzz: got %b want 1", dot_buzzer);
        end
        Reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({dot_buzzer, dash_buzzer, spa_end, overflow, dropped, cq.sent} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_buzz_reset: got %b want 000000",
                {dot_buzzer, dash_buzzer, spa_end, overflow, dropped, cq.sent});
        end
        Dot = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (dot_buzzer !== 1'b0 || cq.sent !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got %b/%b want 0/0",
                dot_buzzer, cq.sent);
        end
    endtask

    initial begin
        test_reset();
        test_dot_endseq();
        test_dash_queue();
        test_space();
        test_overflow();
        test_back_to_back();
        test_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/morse_producer_fifo.md
Name: morse_producer_fifo

Overview:
- Parametrised successor to the single-character Morse producer.
- Turns the Dot/Dash/Space/EndSeq/Clear push-buttons into packed Morse code words of configurable length.
- Drives dot/dash buzzers with timed pulses.
- Queues committed words in an internal FIFO, which the consumer drains with a valid/acknowledge handshake. Sits between the button front-end and the transmitter/consumer side.

Parameters:
- MAX_SYMBOLS, 5: max dots/dashes per character; code word width W = 2*MAX_SYMBOLS.
- BUZZ_CYCLES, 8: dot buzzer length in clk cycles; dash buzzer length = 3*BUZZ_CYCLES.
- FIFO_DEPTH, 4: committed-word queue depth; power of two, >= 2.
- DEBOUNCE_CYCLES, 4: stable-high cycles required per button; used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-low reset (Reset=0 resets at the next clk edge).
- Dot  in  1  dot button, level.
- Dash  in  1  dash button, level.
- Space  in  1  word-gap button, level.
- EndSeq  in  1  end-of-character button, level.
- Clear  in  1  discard-current-character button, level.
- Ack  in  1  consumer accepts FIFO head this cycle.
- dot_buzzer  out  1  high while a dot tone plays.
- dash_buzzer  out  1  high while a dash tone plays.
- outputbits  out  W  FIFO head code word.
- sent  out  1  FIFO non-empty; outputbits valid.
- spa_end  out  1  one-cycle pulse when Space or EndSeq is accepted.
- overflow  out  1  sticky: Dot/Dash rejected because the buffer held MAX_SYMBOLS.
- dropped  out  1  one-cycle pulse: a commit was lost because the FIFO was full.

Behaviour:
- Reset (Reset=0): all outputs 0; buffer empty; symbol count 0; FIFO empty; buzzer counters 0; FSM in IDLE; edge-detect history cleared.
- Input conditioning:
  - Each button passes through one sync flop plus an edge detect (rise = s1 & ~s2).
  - A button sampled high at edge N is acted on at edge N+1.
  - A held button produces exactly one event.
- Symbol encoding (2 bits per symbol):
  - 01 = dot, 10 = dash.
  - Buffer shifts left by 2 and the new symbol enters the LSBs; unused MSB slots stay 00.
  - Word-separator entry = all ones (W'h3FF at defaults).
- Same-cycle priority: Clear > EndSeq > Space > Dash > Dot. Lower-priority events that cycle are discarded.
- Dot/Dash:
  - If count < MAX_SYMBOLS: append, count+1, start the buzzer.
  - Otherwise: ignore and set overflow.
  - Buzzer: dot_buzzer for BUZZ_CYCLES, dash_buzzer for 3*BUZZ_CYCLES. A new accepted symbol cancels the other buzzer and restarts the count.
- EndSeq:
  - If count > 0: push the buffer to the FIFO, clear the buffer and count, clear overflow.
  - If count = 0: no push.
  - Always pulse spa_end.
- Space:
  - Pulses spa_end.
  - Buffer empty: push the separator.
  - Buffer non-empty: push the buffer this cycle, FSM IDLE -> PEND_SPACE, push the separator next cycle, then PEND_SPACE -> IDLE.
  - Button events arriving while in PEND_SPACE are ignored.
- Clear: empty the buffer, count 0, clear overflow, stop both buzzers. The FIFO is untouched.
- FIFO:
  - sent = (occupancy != 0); outputbits = head word; the head advances at an edge with sent & Ack.
  - Ack while empty is ignored.
  - Push and pop in the same cycle are both allowed, including when full: the pop frees the slot, so the push succeeds.
  - A push when full with no pop: the word is discarded and dropped pulses.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH.
- Reset mid-operation: takes effect at the next edge regardless of FSM state, a pending space or an active buzzer. A pending separator is lost.

Optional Feature:
- Macro: MORSE_DEBOUNCE_EN.
- Defined: each synchronised button must read high for DEBOUNCE_CYCLES consecutive cycles before its event fires. Response latency becomes DEBOUNCE_CYCLES+1 edges. A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Undefined: plain sync + edge detect as above; the DEBOUNCE_CYCLES parameter is unused.

Test Plan:
- Dot x3, then EndSeq, no Ack (defaults) -> sent=1, outputbits=10'h015, spa_end one pulse, each dot gives dot_buzzer high 8 cycles.
- Dash x3, EndSeq, Dot x3, EndSeq, then Ack pulses -> heads 10'h02A then 10'h015, then sent=0. dash_buzzer high 24 cycles per dash.
- Dot x3, then Space -> FIFO receives 10'h015 then 10'h3FF on consecutive cycles; FSM returns to IDLE.
- Dot x6, EndSeq -> 6th dot rejected, overflow=1, pushed word 10'h155; overflow clears after EndSeq.
- Fill FIFO with 4 words, commit a 5th with Ack=0 -> dropped pulses, occupancy 4. Repeat with Ack=1 on the push cycle -> no drop, occupancy stays 4.
- Dot and Clear rising on the same edge, then Dot held 3 cycles with Reset=0 mid-buzz -> Clear wins (no symbol); after reset all outputs 0 and sent=0.
